// File: rtl/risc_alu.sv
// rtl/risc_alu.sv - 16-bit execute-stage ALU with registered Z/V/N condition flags
//
// Purpose: combinational result for a 4-bit opcode over two 16-bit operands
//          (saturating add/sub, xor, nibble reduction, shifts/rotate,
//          nibble-parallel saturating add, address generation, byte loads),
//          plus the 3-bit condition-flag register updated on rising clk.
// Optional: define ALU_FLAG_WE_EN to add the flag_we write-enable input.
// Ports:
//   clk     in   1  rising-edge clock for the flag register
//   rst     in   1  asynchronous active-high reset, clears flags
//   a       in  16  operand 1 (rs)
//   b       in  16  operand 2 (rt, immediate or shift amount)
//   op      in   4  operation select
//   flag_we in   1  flag write enable (only with ALU_FLAG_WE_EN)
//   result  out 16  combinational result
//   flags   out  3  registered flags: [2]=Z, [1]=V, [0]=N
module risc_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
`ifdef ALU_FLAG_WE_EN
  input  logic        flag_we,
`endif
  output logic [15:0] result,
  output logic [2:0]  flags
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;

  logic        we;
  logic [3:0]  sh;
  logic [16:0] add_x;
  logic [16:0] sub_x;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] add_sat;
  logic [15:0] sub_sat;
  logic [15:0] ror_res;
  logic [6:0]  red_acc;
  logic [15:0] padd_res;
  logic        ovf;

`ifdef ALU_FLAG_WE_EN
  assign we = flag_we;
`else
  assign we = 1'b1;
`endif

  // Shift/rotate only look at the low four bits of b.
  assign sh = b[3:0];

  // 17-bit sign-extended sums: top two bits disagree exactly on signed overflow,
  // and the top bit then gives the direction of saturation.
  assign add_x   = {a[15], a} + {b[15], b};
  assign sub_x   = {a[15], a} - {b[15], b};
  assign add_ovf = add_x[16] ^ add_x[15];
  assign sub_ovf = sub_x[16] ^ sub_x[15];
  assign add_sat = add_ovf ? (add_x[16] ? 16'h8000 : 16'h7FFF) : add_x[15:0];
  assign sub_sat = sub_ovf ? (sub_x[16] ? 16'h8000 : 16'h7FFF) : sub_x[15:0];

  // Left shift by 16 in a 16-bit context yields zero, so amount 0 returns a.
  assign ror_res = (a >> sh) | (a << (5'd16 - {1'b0, sh}));

  // Eight signed nibbles sum into -64..+56, which fits a 7-bit signed accumulator.
  always_comb begin
    red_acc = 7'd0;
    for (int i = 0; i < 4; i++) begin
      red_acc = red_acc + {{3{a[4*i+3]}}, a[4*i +: 4]}
                        + {{3{b[4*i+3]}}, b[4*i +: 4]};
    end
  end

  // Four isolated 4-bit saturating lanes; each lane uses its own 5-bit sum.
  always_comb begin
    logic [4:0] ls;
    padd_res = 16'h0000;
    ls       = 5'd0;
    for (int i = 0; i < 4; i++) begin
      ls = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (ls[4] != ls[3]) begin
        padd_res[4*i +: 4] = ls[4] ? 4'h8 : 4'h7;
      end else begin
        padd_res[4*i +: 4] = ls[3:0];
      end
    end
  end

  always_comb begin
    result = 16'h0000;
    ovf    = 1'b0;
    case (op)
      OP_ADD:    begin result = add_sat; ovf = add_ovf; end
      OP_SUB:    begin result = sub_sat; ovf = sub_ovf; end
      OP_XOR:    result = a ^ b;
      OP_RED:    result = {{9{red_acc[6]}}, red_acc};
      OP_SLL:    result = a << sh;
      OP_SRA:    result = $signed(a) >>> sh;
      OP_ROR:    result = ror_res;
      OP_PADDSB: result = padd_res;
      OP_LW,
      OP_SW:     result = (a & 16'hFFFE) + b;
      OP_LLB:    result = {a[15:8], b[7:0]};
      OP_LHB:    result = {b[7:0], a[7:0]};
      default:   result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 3'b000;
    end else if (we) begin
      case (op)
        OP_ADD, OP_SUB: flags <= {(result == 16'h0000), ovf, result[15]};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags[2] <= (result == 16'h0000);
        default: flags <= flags;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_alu.sv
// tb/tb_risc_alu.sv - self-checking bench for risc_alu against a behavioural model
module tb_risc_alu;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
`ifdef ALU_FLAG_WE_EN
  logic        flag_we;
`endif
  logic [15:0] result;
  logic [2:0]  flags;

  int tests;
  int fails;
  logic [2:0] eflags;

  risc_alu dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .op     (op),
`ifdef ALU_FLAG_WE_EN
    .flag_we(flag_we),
`endif
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nib(input logic [15:0] x, input int i);
    int v;
    v = int'((x >> (4 * i)) & 16'h000F);
    if (v >= 8) v = v - 16;
    return v;
  endfunction

  // Returns {overflow, result} computed with plain integer arithmetic.
  function automatic logic [16:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int s;
    int t;
    int n;
    logic [31:0] w;
    logic [15:0] r;
    logic v;
    v = 1'b0;
    r = 16'h0000;
    n = int'(y & 16'h000F);
    case (o)
      4'd0, 4'd1: begin
        s = (o == 4'd0) ? int'($signed(x)) + int'($signed(y)) : int'($signed(x)) - int'($signed(y));
        if (s > 32767) begin r = 16'h7FFF; v = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
        else begin w = s; r = w[15:0]; end
      end
      4'd2: r = x ^ y;
      4'd3: begin
        s = 0;
        for (int i = 0; i < 4; i++) s = s + nib(x, i) + nib(y, i);
        w = s;
        r = w[15:0];
      end
      4'd4: begin w = {16'h0, x} << n; r = w[15:0]; end
      4'd5: begin s = int'($signed(x)) >>> n; w = s; r = w[15:0]; end
      4'd6: begin
        w = {16'h0, x};
        w = (w >> n) | (w << (16 - n));
        r = w[15:0];
      end
      4'd7: begin
        for (int i = 0; i < 4; i++) begin
          t = nib(x, i) + nib(y, i);
          if (t > 7) t = 7;
          if (t < -8) t = -8;
          w = t;
          r = r | ({12'h0, w[3:0]} << (4 * i));
        end
      end
      4'd8, 4'd9: begin w = int'(x) - int'(x % 2) + int'(y); r = w[15:0]; end
      4'd10: r = (x & 16'hFF00) | (y & 16'h00FF);
      4'd11: r = ((y & 16'h00FF) * 16'd256) | (x & 16'h00FF);
      default: r = 16'h0000;
    endcase
    return {v, r};
  endfunction

  // Next flag value given the current flags and a model result.
  function automatic logic [2:0] next_flags(input logic [2:0] cur, input logic [3:0] o, input logic [16:0] m);
    logic [2:0] f;
    f = cur;
    if (o == 4'd0 || o == 4'd1) f = {(m[15:0] == 16'h0), m[16], m[15]};
    else if (o == 4'd2 || o == 4'd4 || o == 4'd5 || o == 4'd6) f[2] = (m[15:0] == 16'h0);
    return f;
  endfunction

  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(4'd2, 16'hF0F0, 16'h0FF0);
    tests++;
    if (flags !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000", flags);
    end
    tests++;
    if (result !== 16'hFF00) begin
      fails++;
      $display("FAIL reset_result: got %h want ff00", result);
    end
    @(negedge clk);
    rst = 1'b0;
    eflags = 3'b000;
  endtask

  task automatic test_directed;
    logic [3:0]  ops [16] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd11,
                              4'd3, 4'd7, 4'd2, 4'd4, 4'd5, 4'd6, 4'd12, 4'd1};
    logic [15:0] as  [16] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h5A5A, 16'hAB77, 16'hCDEF, 16'hAB77, 16'hABF9,
                              16'hABCD, 16'hAB70, 16'hFAB3, 16'hFFFF, 16'h8210, 16'h82AB, 16'hFFFF, 16'h1234};
    logic [15:0] bs  [16] = '{16'h4321, 16'h0123, 16'h0010, 16'h5A5A, 16'h0050, 16'h0052, 16'h0059, 16'h0056,
                              16'h1234, 16'h572F, 16'h2897, 16'hABC5, 16'h0028, 16'h2F2A, 16'hFFFF, 16'h0123};
    logic [15:0] rs  [16] = '{16'h5555, 16'h7FFF, 16'h8000, 16'h0000, 16'hABC6, 16'hCE40, 16'hAB59, 16'h56F9,
                              16'hFFF8, 16'hF27F, 16'hD224, 16'hFFE0, 16'hFF82, 16'hAAE0, 16'h0000, 16'h1111};
    logic [2:0]  fs  [16] = '{3'b000, 3'b010, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                              3'b111, 3'b111, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
`ifdef ALU_FLAG_WE_EN
    flag_we = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      drive(ops[i], as[i], bs[i]);
      tests++;
      if (result !== rs[i]) begin
        fails++;
        $display("FAIL directed_result[%0d] op=%h: got %h want %h", i, ops[i], result, rs[i]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (flags !== fs[i]) begin
        fails++;
        $display("FAIL directed_flags[%0d] op=%h: got %b want %b", i, ops[i], flags, fs[i]);
      end
    end
    eflags = 3'b000;
  endtask

  task automatic test_random(input int count);
    logic [16:0] m;
    logic [3:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
    for (int i = 0; i < count; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = 16'($urandom);
      // Bias a fraction of add/sub toward the saturation boundaries.
      if ($urandom_range(0, 3) == 0) begin
        x = ($urandom_range(0, 1) == 1) ? 16'h7FFF - 16'($urandom_range(0, 3)) : 16'h8000 + 16'($urandom_range(0, 3));
        y = 16'($urandom_range(0, 1) == 1 ? $urandom_range(0, 4) : 16'hFFFF - $urandom_range(0, 4));
      end
      if ($urandom_range(0, 7) == 0) y = x;
      en = 1'b1;
`ifdef ALU_FLAG_WE_EN
      en = 1'($urandom_range(0, 1));
      flag_we = en;
`endif
      drive(o, x, y);
      m = model(o, x, y);
      tests++;
      if (result !== m[15:0]) begin
        fails++;
        $display("FAIL random_result op=%h a=%h b=%h: got %h want %h", o, x, y, result, m[15:0]);
      end
      if (en) eflags = next_flags(eflags, o, m);
      @(posedge clk);
      #1;
      tests++;
      if (flags !== eflags) begin
        fails++;
        $display("FAIL random_flags op=%h a=%h b=%h: got %b want %b", o, x, y, flags, eflags);
      end
    end
`ifdef ALU_FLAG_WE_EN
    flag_we = 1'b1;
`endif
  endtask

  task automatic test_async_reset;
    // 0x8000 + 0xFFFF saturates negative: Z=0 V=1 N=1.
    drive(4'd0, 16'h8000, 16'hFFFF);
    @(posedge clk);
    #1;
    tests++;
    if (flags !== 3'b011) begin
      fails++;
      $display("FAIL async_setup: got %b want 011", flags);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (flags !== 3'b000) begin
      fails++;
      $display("FAIL async_clear: got %b want 000", flags);
    end
    @(posedge clk);
    #1;
    tests++;
    if (flags !== 3'b000) begin
      fails++;
      $display("FAIL async_hold: got %b want 000", flags);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (flags !== 3'b011) begin
      fails++;
      $display("FAIL reset_release_update: got %b want 011", flags);
    end
    eflags = 3'b011;
  endtask

`ifdef ALU_FLAG_WE_EN
  task automatic test_flag_we;
    flag_we = 1'b1;
    drive(4'd1, 16'h1234, 16'h1234);
    @(posedge clk);
    #1;
    flag_we = 1'b0;
    drive(4'd0, 16'h7FFF, 16'h0001);
    tests++;
    if (result !== 16'h7FFF) begin
      fails++;
      $display("FAIL flag_we_result: got %h want 7fff", result);
    end
    @(posedge clk);
    #1;
    tests++;
    if (flags !== 3'b100) begin
      fails++;
      $display("FAIL flag_we_hold: got %b want 100", flags);
    end
    flag_we = 1'b1;
    eflags = 3'b100;
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    eflags = 3'b000;
    rst = 1'b1;
    op = 4'd0;
    a = 16'h0;
    b = 16'h0;
`ifdef ALU_FLAG_WE_EN
    flag_we = 1'b1;
`endif
    test_reset;
    test_directed;
    test_async_reset;
`ifdef ALU_FLAG_WE_EN
    test_flag_we;
`endif
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- 16-bit execute-stage ALU for the RISC core: 4-bit opcode, two 16-bit operands.
- Computes a combinational result: saturating add/sub, XOR, nibble reduction, shifts/rotate, nibble-parallel saturating add, memory address generation, and byte loads.
- Holds the processor's 3-bit condition-flag register (Z, V, N), updated on the clock edge by flag-setting ops.

Parameters:
- none (datapath fixed at 16 bits, opcode at 4 bits)

Ports:
- clk  in  1  rising-edge clock for flag register
- rst  in  1  asynchronous active-high reset; clears flag register
- a  in  16  operand 1 (rs)
- b  in  16  operand 2 (rt, or immediate/shift amount in low bits)
- op  in  4  operation select
- result  out  16  combinational result
- flags  out  3  registered flags: [2]=Z, [1]=V, [0]=N
- flag_we  in  1  present only with ALU_FLAG_WE_EN (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- result is purely combinational, zero latency from a/b/op. Unaffected by clk/rst.
- 0000 ADD: a+b, signed 16-bit saturating.
  - pos overflow -> 0x7FFF; neg overflow -> 0x8000.
- 0001 SUB: a-b, same saturation rules.
- 0010 XOR: a^b.
- 0011 RED: sum of the eight 4-bit signed (two's-complement) nibbles of a and b. Exact (range -64..+56), sign-extended to 16 bits.
- 0100 SLL: a << b[3:0], zero fill.
- 0101 SRA: a >>> b[3:0], sign fill.
- 0110 ROR: a rotated right by b[3:0]; amount 0 -> a.
- 0111 PADDSB: four independent 4-bit signed saturating adds, a[4i+3:4i]+b[4i+3:4i].
  - Each lane clamps to 0x7 or 0x8; no carry between lanes.
- 1000 LW / 1001 SW: (a & 0xFFFE) + b, plain modulo-2^16, no saturation.
- 1010 LLB: {a[15:8], b[7:0]}.
- 1011 LHB: {b[7:0], a[7:0]}.
- 1100-1111: result = 0x0000.
- Flag next-state, computed from the final (saturated) result:
  - Z = (result==0)
  - V = signed overflow occurred (saturation triggered)
  - N = result[15]
- Flag update rules, at each rising clk:
  - ADD, SUB: write Z, V, N.
  - XOR, SLL, SRA, ROR: write Z only; V and N hold.
  - All other ops: flags hold.
- rst=1: flags -> 3'b000 immediately, regardless of clk; held while rst asserted.
  - First update occurs on the first rising edge after deassert.
- Shift/rotate ignore b[15:4].
- RED and PADDSB never set V.

Optional Feature:
- Macro ALU_FLAG_WE_EN.
- Defined: adds input flag_we. Flag register writes per the rules above only when flag_we=1; flag_we=0 holds all flags (pipeline stall/flush). Reset unaffected.
- Undefined: no flag_we port; writes occur every edge per the op rules.

Test Plan:
- ADD a=0x1234 b=0x4321 -> result 0x5555; after clk flags Z=0 V=0 N=0.
- ADD a=0x7FFF b=0x0123 -> 0x7FFF, V=1 after clk. SUB a=0x8000 b=0x0010 -> 0x8000, V=1 N=1. SUB a=0x1234 b=0x0123 -> 0x1111.
- XOR 0xFAB3^0x2897 -> 0xD224. RED a=0xABCD b=0x1234 -> 0xFFF8. PADDSB a=0xAB70 b=0x572F -> 0xF27F.
- SLL a=0xFFFF b=0xABC5 -> 0xFFE0. SRA a=0x8210 b=0x0028 -> 0xFF82. ROR a=0x82AB b=0x2F2A -> 0xAAE0. XOR a=b=0x5A5A -> 0x0000, Z=1 after clk with V/N held.
- LW a=0xAB77 b=0x0050 -> 0xABC6. SW a=0xCDEF b=0x0052 -> 0xCE40. LLB a=0xAB77 b=0x0059 -> 0xAB59. LHB a=0xABF9 b=0x0056 -> 0x56F9. None of these change flags.
- Set flags nonzero, assert rst between edges -> flags 0 immediately. With ALU_FLAG_WE_EN and flag_we=0, ADD 0x7FFF+1 leaves flags unchanged.
